// File: rtl/demux8_1_reg.sv
// Registered 1-to-8 demultiplexer for 5-bit words with valid flags, an auto-increment pointer,
// a sticky overflow flag and an 8-cycle sequential clear sweep.
//
// state | meaning
// IDLE  | accepting writes; clr starts a sweep
// CLEAR | clearing Y[cnt]/valid[cnt] one index per cycle, inputs ignored
module demux8_1_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] D,
  input  logic       SEL0,
  input  logic       SEL1,
  input  logic       SEL2,
  input  logic       wr,
  input  logic       auto,
  input  logic       clr,
  output logic [4:0] Y0,
  output logic [4:0] Y1,
  output logic [4:0] Y2,
  output logic [4:0] Y3,
  output logic [4:0] Y4,
  output logic [4:0] Y5,
  output logic [4:0] Y6,
  output logic [4:0] Y7,
  output logic [7:0] valid,
  output logic       full,
  output logic       busy,
  output logic [2:0] ptr,
  output logic       ovf
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      addr;
  logic [7:0][4:0] y_q;
  logic            clr_start;
  logic            wr_ok;

  assign addr      = auto ? ptr : {SEL0, SEL1, SEL2};
  assign clr_start = (state == IDLE) && clr;
  // clr has priority over a simultaneous write
  assign wr_ok     = (state == IDLE) && !clr && wr;

  assign full = &valid;
  assign busy = (state == CLEAR);

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (cnt == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      valid <= '0;
      ptr   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (clr_start) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      y_q[cnt]   <= '0;
      valid[cnt] <= 1'b0;
      cnt        <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        ptr <= '0;
        ovf <= 1'b0;
      end
    end else if (wr_ok) begin
      y_q[addr]   <= D;
      valid[addr] <= 1'b1;
      if (auto) begin
        ptr <= ptr + 3'd1;
        if (full) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux8_1_reg.sv
// Self-checking bench for demux8_1_reg: table-driven writes through a scoreboard queue,
// plus hand-written clear-sweep, wr+clr collision and mid-sweep reset sequences.
module tb_demux8_1_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] D = '0;
  logic       SEL0 = 1'b0, SEL1 = 1'b0, SEL2 = 1'b0;
  logic       wr = 1'b0, auto = 1'b0, clr = 1'b0;
  logic [4:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [7:0] valid;
  logic       full, busy, ovf;
  logic [2:0] ptr;

  int checks = 0;
  int errors = 0;

  demux8_1_reg dut (
    .clk(clk), .rst(rst), .D(D), .SEL0(SEL0), .SEL1(SEL1), .SEL2(SEL2),
    .wr(wr), .auto(auto), .clr(clr),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
    .valid(valid), .full(full), .busy(busy), .ptr(ptr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       am;
    logic [4:0] d;
    logic [2:0] cidx;
    logic [4:0] ey;
    logic [7:0] ev;
    logic [2:0] ep;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t vecs [22];
  vec_t sbq [$];

  function automatic vec_t mk(input logic [2:0] idx, input logic am, input logic [4:0] d,
                              input logic [2:0] cidx, input logic [4:0] ey, input logic [7:0] ev,
                              input logic [2:0] ep, input logic ef, input logic eo);
    vec_t v;
    v.idx = idx; v.am = am; v.d = d; v.cidx = cidx; v.ey = ey;
    v.ev = ev; v.ep = ep; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  function automatic logic [4:0] get_y(input int k);
    case (k)
      0: return Y0;
      1: return Y1;
      2: return Y2;
      3: return Y3;
      4: return Y4;
      5: return Y5;
      6: return Y6;
      default: return Y7;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t e;
    @(negedge clk);
    {SEL0, SEL1, SEL2} = vecs[i].idx;
    auto = vecs[i].am;
    D    = vecs[i].d;
    clr  = 1'b0;
    wr   = 1'b1;
    sbq.push_back(vecs[i]);
    @(posedge clk);
    #1;
    wr = 1'b0;
    e = sbq.pop_front();
    chk($sformatf("vec%0d Y%0d", i, e.cidx), 32'(get_y(int'(e.cidx))), 32'(e.ey));
    chk($sformatf("vec%0d valid", i), 32'(valid), 32'(e.ev));
    chk($sformatf("vec%0d ptr", i), 32'(ptr), 32'(e.ep));
    chk($sformatf("vec%0d full", i), 32'(full), 32'(e.ef));
    chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(e.eo));
    chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
  endtask

  // Starts a sweep, hammers wr/clr during it, and checks each cleared index.
  task automatic clear_sweep(input logic wr_too, input logic [7:0] start_valid, input logic ovf_before);
    logic [7:0] mask;
    @(negedge clk);
    {SEL0, SEL1, SEL2} = 3'd3;
    auto = 1'b0;
    D    = 5'h1F;
    wr   = wr_too;
    clr  = 1'b1;
    @(posedge clk);
    #1;
    chk("sweep start busy", 32'(busy), 32'd1);
    chk("sweep start valid", 32'(valid), 32'(start_valid));
    chk("sweep start ovf", 32'(ovf), 32'(ovf_before));
    if (wr_too) chk("wr+clr Y3", 32'(Y3), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wr   = 1'b1;
      auto = 1'b1;
      D    = 5'h1F;
      clr  = (k == 2);
      @(posedge clk);
      #1;
      mask = 8'hFF << (k + 1);
      chk($sformatf("sweep%0d valid", k), 32'(valid), 32'(start_valid & mask));
      chk($sformatf("sweep%0d busy", k), 32'(busy), (k != 7) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d Y%0d", k, k), 32'(get_y(k)), 32'd0);
      if (wr_too) chk($sformatf("wr+clr%0d Y3", k), 32'(Y3), 32'd0);
    end
    wr  = 1'b0;
    clr = 1'b0;
    chk("sweep end ptr", 32'(ptr), 32'd0);
    chk("sweep end ovf", 32'(ovf), 32'd0);
    chk("sweep end full", 32'(full), 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("sweep end Y%0d", k), 32'(get_y(k)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(3'd6, 1'b0, 5'h15, 3'd6, 5'h15, 8'h40, 3'd0, 1'b0, 1'b0);
    vecs[1]  = mk(3'd0, 1'b0, 5'd1,  3'd0, 5'd1,  8'h41, 3'd0, 1'b0, 1'b0);
    vecs[2]  = mk(3'd1, 1'b0, 5'd2,  3'd1, 5'd2,  8'h43, 3'd0, 1'b0, 1'b0);
    vecs[3]  = mk(3'd2, 1'b0, 5'd3,  3'd2, 5'd3,  8'h47, 3'd0, 1'b0, 1'b0);
    vecs[4]  = mk(3'd3, 1'b0, 5'd4,  3'd3, 5'd4,  8'h4F, 3'd0, 1'b0, 1'b0);
    vecs[5]  = mk(3'd4, 1'b0, 5'd5,  3'd4, 5'd5,  8'h5F, 3'd0, 1'b0, 1'b0);
    vecs[6]  = mk(3'd5, 1'b0, 5'd6,  3'd5, 5'd6,  8'h7F, 3'd0, 1'b0, 1'b0);
    vecs[7]  = mk(3'd6, 1'b0, 5'd7,  3'd6, 5'd7,  8'h7F, 3'd0, 1'b0, 1'b0);
    vecs[8]  = mk(3'd7, 1'b0, 5'd8,  3'd7, 5'd8,  8'hFF, 3'd0, 1'b1, 1'b0);
    vecs[9]  = mk(3'd5, 1'b1, 5'd1,  3'd0, 5'd1,  8'h01, 3'd1, 1'b0, 1'b0);
    vecs[10] = mk(3'd5, 1'b1, 5'd2,  3'd1, 5'd2,  8'h03, 3'd2, 1'b0, 1'b0);
    vecs[11] = mk(3'd5, 1'b1, 5'd3,  3'd2, 5'd3,  8'h07, 3'd3, 1'b0, 1'b0);
    vecs[12] = mk(3'd5, 1'b1, 5'd4,  3'd3, 5'd4,  8'h0F, 3'd4, 1'b0, 1'b0);
    vecs[13] = mk(3'd5, 1'b1, 5'd5,  3'd4, 5'd5,  8'h1F, 3'd5, 1'b0, 1'b0);
    vecs[14] = mk(3'd5, 1'b1, 5'd6,  3'd5, 5'd6,  8'h3F, 3'd6, 1'b0, 1'b0);
    vecs[15] = mk(3'd5, 1'b1, 5'd7,  3'd6, 5'd7,  8'h7F, 3'd7, 1'b0, 1'b0);
    vecs[16] = mk(3'd5, 1'b1, 5'd8,  3'd7, 5'd8,  8'hFF, 3'd0, 1'b1, 1'b0);
    vecs[17] = mk(3'd5, 1'b1, 5'd9,  3'd0, 5'd9,  8'hFF, 3'd1, 1'b1, 1'b1);
    vecs[18] = mk(3'd2, 1'b0, 5'h0A, 3'd2, 5'h0A, 8'hFF, 3'd1, 1'b1, 1'b1);
    vecs[19] = mk(3'd7, 1'b0, 5'h11, 3'd7, 5'h11, 8'h80, 3'd0, 1'b0, 1'b0);
    vecs[20] = mk(3'd3, 1'b1, 5'h04, 3'd0, 5'h04, 8'h81, 3'd1, 1'b0, 1'b0);
    vecs[21] = mk(3'd5, 1'b0, 5'h0C, 3'd5, 5'h0C, 8'h20, 3'd0, 1'b0, 1'b0);

    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("reset Y%0d", k), 32'(get_y(k)), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset ptr", 32'(ptr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= 8; i++) run_vec(i);
    for (int k = 0; k < 8; k++) chk($sformatf("manual Y%0d", k), 32'(get_y(k)), 32'(k + 1));

    clear_sweep(1'b0, 8'hFF, 1'b0);

    for (int i = 9; i <= 17; i++) run_vec(i);
    chk("wrap Y0", 32'(Y0), 32'd9);
    for (int k = 1; k < 8; k++) chk($sformatf("wrap Y%0d", k), 32'(get_y(k)), 32'(k + 1));
    run_vec(18);

    clear_sweep(1'b0, 8'hFF, 1'b1);
    clear_sweep(1'b1, 8'h00, 1'b0);

    run_vec(19);
    run_vec(20);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("rst-sweep busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("midsweep rst Y%0d", k), 32'(get_y(k)), 32'd0);
    chk("midsweep rst valid", 32'(valid), 32'd0);
    chk("midsweep rst ptr", 32'(ptr), 32'd0);
    chk("midsweep rst busy", 32'(busy), 32'd0);
    chk("midsweep rst ovf", 32'(ovf), 32'd0);
    chk("midsweep rst full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux8_1_reg.md
# demux8_1_reg

Registered 1-to-8 demultiplexer for 5-bit data: the write-side counterpart of the 8-to-1 5-bit selector in PROJETO 2. It captures a 5-bit word into one of eight holding registers Y0..Y7. The register is chosen either by the SEL0..SEL2 lines or by an internal auto-increment pointer. A per-register valid flag and an 8-cycle sequential clear sweep let the selector side read only meaningful data.

## Interface
Parameters: none (width fixed at 5, depth fixed at 8).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- D  in  5  data word to store
- SEL0  in  1  manual address bit, weight 4 (MSB)
- SEL1  in  1  manual address bit, weight 2
- SEL2  in  1  manual address bit, weight 1 (LSB)
- wr  in  1  write strobe; one word per cycle while high
- auto  in  1  1 = address from internal pointer, 0 = address from SEL0..SEL2
- clr  in  1  start clear sweep (sampled only when idle)
- Y0..Y7  out  5 each  holding registers
- valid  out  8  valid[k] = Yk written since last reset/clear
- full  out  1  all eight valid bits set (combinational AND of valid)
- busy  out  1  clear sweep in progress
- ptr  out  3  current auto pointer
- ovf  out  1  sticky overflow flag

## Operation
- Address decode: manual index = SEL0*4 + SEL1*2 + SEL2. Index 0 selects Y0, and index 7 selects Y7.
- States: IDLE, CLEAR. A 3-bit sweep counter cnt is used only in CLEAR.
- IDLE, wr=1, clr=0:
  - Y[addr] <= D and valid[addr] <= 1.
  - addr = ptr if auto=1, else the manual index.
  - Writing an already-valid register overwrites it; its valid bit stays 1.
- Auto pointer:
  - ptr increments by 1 after each accepted write with auto=1, wrapping 7 -> 0.
  - Manual writes leave ptr unchanged.
- Overflow: an accepted auto write while full=1 sets ovf. The write still happens and ptr still advances. ovf clears only on reset or at the end of a clear sweep.
- IDLE, clr=1:
  - Go to CLEAR with cnt <= 0 and busy <= 1.
  - If wr=1 in the same cycle, clr wins and the write is dropped with no state change.
- CLEAR:
  - Each cycle: Y[cnt] <= 0, valid[cnt] <= 0, cnt <= cnt+1.
  - After clearing index 7: ptr <= 0, ovf <= 0, busy <= 0, return to IDLE.
  - wr and clr are ignored for the whole sweep.
- Reset, asynchronous at any time including mid-sweep:
  - Y0..Y7 = 0, valid = 0, ptr = 0, ovf = 0, busy = 0, state = IDLE, cnt = 0.
  - full is therefore 0.

## Timing
- Write latency 1: wr sampled at edge N, so Y/valid/ptr/ovf are updated after edge N.
- full follows valid combinationally, so it is also valid after edge N.
- Back-to-back writes are accepted every cycle, with no bubbles.
- Clear sweep for clr sampled at edge N:
  - busy = 1 after edge N.
  - Register k is cleared at edge N+1+k, for k = 0..7.
  - busy = 0, ptr = 0, ovf = 0 after edge N+8.
  - First new write is accepted at edge N+9.
- Clear duration is exactly 8 cycles of busy=1, independent of inputs.
- Outputs are registered except full.

## Test plan
- Reset values: assert rst mid-cycle -> immediately Y0..Y7=0, valid=8'h00, ptr=0, busy=0, ovf=0, full=0.
- Manual write and decode: write D=5'h15 with SEL0..SEL2=1,1,0 (index 6) -> Y6=5'h15, valid=8'h40, ptr=0. Repeat for all eight indices with D=index+1 -> Yk=k+1, valid=8'hFF, full=1.
- Auto wrap and overflow:
  - auto=1, nine consecutive writes D=1..9 -> Y0=9, Y1..Y7=2..8.
  - ptr sequence 1..7,0,1.
  - full=1 after the 8th write; ovf=1 after the 9th.
- Clear sweep:
  - With valid=8'hFF, pulse clr -> busy high for 8 cycles.
  - valid falls one bit per cycle, LSB first (FE, FC, ... 00).
  - At end: all Y=0, ptr=0, ovf=0.
  - wr pulses during the sweep have no effect.
- Simultaneous wr+clr in IDLE: D=5'h1F, index 3, both high -> no write; Y3 stays 0 through the sweep; busy=1.
- Reset mid-sweep: assert rst at sweep cycle 3 -> all outputs return to reset values at once. After release, a write to index 5 is accepted on the next edge.
